// File: rtl/md_pkg.sv
// Shared encodings for the multiply/divide HI/LO unit: request opcodes, FSM states
// and the divide latency helper.
package md_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic [2:0] {
    StIdle,
    StMul,
    StDivPre,
    StDivIter,
    StDivPost
  } md_state_e;

  // Cycles from accept to the HI/LO update of a full-length divide.
  function automatic int unsigned div_latency(input int unsigned xlen);
    return xlen + 2;
  endfunction

endpackage

// File: rtl/md_div_iter.sv
// Restoring radix-2 divider core on unsigned magnitudes: one quotient bit per cycle,
// MSB first, XLEN iterations after start.
module md_div_iter #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            abort,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            finish,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int unsigned CntW = $clog2(XLEN + 1);

  logic [XLEN-1:0] rem_q, quo_q, dsr_q;
  logic [CntW-1:0] cnt_q;
  logic [XLEN:0]   partial;
  logic [XLEN-1:0] diff;
  logic            fits;

  // Shift the next dividend bit into the partial remainder and trial-subtract.
  always_comb begin
    partial = {rem_q, quo_q[XLEN-1]};
    fits    = partial >= {1'b0, dsr_q};
    diff    = partial[XLEN-1:0] - dsr_q;
  end

  always_ff @(posedge clk) begin
    if (reset || abort) begin
      rem_q <= '0;
      quo_q <= '0;
      dsr_q <= '0;
      cnt_q <= '0;
    end else if (start) begin
      rem_q <= '0;
      quo_q <= dividend;
      dsr_q <= divisor;
      cnt_q <= CntW'(XLEN);
    end else if (cnt_q != '0) begin
      rem_q <= fits ? diff : partial[XLEN-1:0];
      quo_q <= {quo_q[XLEN-2:0], fits};
      cnt_q <= cnt_q - 1'b1;
    end
  end

  // High during the cycle whose closing edge produces the last quotient bit.
  assign finish    = (cnt_q == CntW'(1));
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/muldiv_hilo_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers and flush.
// Define MUL_DIV_EARLY_EN to let trivial divides skip the iteration phase.
module muldiv_hilo_unit
  import md_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned MUL_STAGES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi_out,
  output logic [XLEN-1:0] lo_out
);

  localparam int unsigned MulCntW = (MUL_STAGES > 1) ? $clog2(MUL_STAGES) : 1;

  md_state_e state_q, state_d;

  logic               accept;
  logic [XLEN-1:0]    a_q, b_q, hi_q, lo_q;
  logic               signed_q, done_q;
  logic [MulCntW-1:0] mul_cnt_q;
  logic               mul_last;

  logic [2*XLEN-1:0]  ext_a, ext_b, mul_comb, mul_result;

  logic [XLEN-1:0]    abs_a, abs_b, iter_quo, iter_rem, quo_fix, rem_fix;
  logic               div_zero, early_hit, early_q, q_neg_q, r_neg_q;
  logic               iter_start, iter_abort, iter_finish;

  assign accept   = req_valid && req_ready;
  assign mul_last = (state_q == StMul) && (mul_cnt_q == '0);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            if (req_op == MD_MULT || req_op == MD_MULTU) begin
              state_d = StMul;
            end else if (req_op == MD_DIV || req_op == MD_DIVU) begin
              state_d = StDivPre;
            end
          end
        end
        StMul:     if (mul_cnt_q == '0) state_d = StIdle;
        StDivPre:  state_d = early_hit ? StDivPost : StDivIter;
        StDivIter: if (iter_finish) state_d = StDivPost;
        StDivPost: state_d = StIdle;
        default:   state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    req_ready  = (state_q == StIdle) && !flush;
    busy       = (state_q != StIdle);
    iter_start = (state_q == StDivPre) && !flush && !early_hit;
    iter_abort = flush;
  end

  // ---------------------------------------------------------- operands
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q       <= '0;
      b_q       <= '0;
      signed_q  <= 1'b0;
      mul_cnt_q <= '0;
    end else if (accept) begin
      a_q       <= req_a;
      b_q       <= req_b;
      signed_q  <= (req_op == MD_MULT) || (req_op == MD_DIV);
      mul_cnt_q <= MulCntW'(MUL_STAGES - 1);
    end else if (state_q == StMul && mul_cnt_q != '0) begin
      mul_cnt_q <= mul_cnt_q - 1'b1;
    end
  end

  // -------------------------------------------------------- multiplier
  // Sign/zero extension to the full width makes the truncated product exact.
  assign ext_a    = {{XLEN{signed_q & a_q[XLEN-1]}}, a_q};
  assign ext_b    = {{XLEN{signed_q & b_q[XLEN-1]}}, b_q};
  assign mul_comb = ext_a * ext_b;

  if (MUL_STAGES == 1) begin : g_mul_direct
    assign mul_result = mul_comb;
  end else begin : g_mul_pipe
    logic [2*XLEN-1:0] pipe_q [MUL_STAGES-1];
    always_ff @(posedge clk) begin
      pipe_q[0] <= mul_comb;
      for (int i = 1; i < MUL_STAGES - 1; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
    assign mul_result = pipe_q[MUL_STAGES-2];
  end

  // ----------------------------------------------------------- divider
  assign abs_a    = (signed_q && a_q[XLEN-1]) ? -a_q : a_q;
  assign abs_b    = (signed_q && b_q[XLEN-1]) ? -b_q : b_q;
  assign div_zero = (b_q == '0);

`ifdef MUL_DIV_EARLY_EN
  assign early_hit = div_zero || (abs_a < abs_b);
`else
  assign early_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      early_q <= 1'b0;
    end else if (state_q == StDivPre) begin
      q_neg_q <= signed_q && (a_q[XLEN-1] ^ b_q[XLEN-1]);
      r_neg_q <= signed_q && a_q[XLEN-1];
      early_q <= early_hit;
    end
  end

  md_div_iter #(
    .XLEN(XLEN)
  ) u_div_iter (
    .clk       (clk),
    .reset     (reset),
    .start     (iter_start),
    .abort     (iter_abort),
    .dividend  (abs_a),
    .divisor   (abs_b),
    .finish    (iter_finish),
    .quotient  (iter_quo),
    .remainder (iter_rem)
  );

  assign quo_fix = q_neg_q ? -iter_quo : iter_quo;
  assign rem_fix = r_neg_q ? -iter_rem : iter_rem;

  // ------------------------------------------------------------ HI/LO
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept && req_op == MD_MTHI) hi_q <= req_a;
      if (accept && req_op == MD_MTLO) lo_q <= req_a;
      if (!flush && mul_last) begin
        {hi_q, lo_q} <= mul_result;
        done_q       <= 1'b1;
      end
      if (!flush && state_q == StDivPost) begin
        done_q <= 1'b1;
        if (div_zero) begin
          lo_q <= '1;
          hi_q <= a_q;
        end else if (early_q) begin
          lo_q <= '0;
          hi_q <= a_q;
        end else begin
          lo_q <= quo_fix;
          hi_q <= rem_fix;
        end
      end
    end
  end

  assign done   = done_q;
  assign hi_out = hi_q;
  assign lo_out = lo_q;

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Scoreboard bench for muldiv_hilo_unit: directed cases, flush/reset cases and
// random traffic checked against an arithmetic reference model.
module tb_muldiv_hilo_unit;

  localparam int XLEN = 32;
  localparam int MS   = 2;

  logic            clk = 1'b0;
  logic            reset, req_valid, flush;
  logic            req_ready, busy, done;
  logic [2:0]      req_op;
  logic [XLEN-1:0] req_a, req_b, hi_out, lo_out;

  muldiv_hilo_unit #(
    .XLEN       (XLEN),
    .MUL_STAGES (MS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .flush     (flush),
    .busy      (busy),
    .done      (done),
    .hi_out    (hi_out),
    .lo_out    (lo_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    int              due;
  } exp_t;

  exp_t            sb[$];
  logic [XLEN-1:0] m_hi, m_lo;
  int              n_chk = 0;
  int              n_fail = 0;

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: results from plain signed/unsigned arithmetic.
  task automatic ref_op(input logic [2:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        output logic [XLEN-1:0] hi, output logic [XLEN-1:0] lo, output int lat);
    longint sa, sbv, ma, mb;
    logic [2*XLEN-1:0] p;
    int ia, ib;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    hi  = '0;
    lo  = '0;
    lat = XLEN + 2;
    case (op)
      3'd0: begin p = 64'(sa * sbv); {hi, lo} = p; lat = MS; end
      3'd1: begin p = {32'b0, a} * {32'b0, b}; {hi, lo} = p; lat = MS; end
      3'd2: begin
        ia = a;
        ib = b;
        if (b == 0) begin lo = '1; hi = a; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin lo = a; hi = '0; end
        else begin lo = ia / ib; hi = ia % ib; end
        ma = (sa < 0) ? -sa : sa;
        mb = (sbv < 0) ? -sbv : sbv;
`ifdef MUL_DIV_EARLY_EN
        if (b == 0 || ma < mb) lat = 2;
`endif
      end
      3'd3: begin
        if (b == 0) begin lo = '1; hi = a; end
        else begin lo = a / b; hi = a % b; end
`ifdef MUL_DIV_EARLY_EN
        if (b == 0 || a < b) lat = 2;
`endif
      end
      default: ;
    endcase
  endtask

  // Issue one request; track=0 leaves the model untouched (flushed ops).
  task automatic issue(input logic [2:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input bit track, output int acc);
    int n = 0;
    exp_t e;
    int lat;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      n_chk++;
      n_fail++;
      $display("FAIL ready_timeout actual=busy required=ready");
    end
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    acc       = cyc + 1;
    if (track) begin
      if (op <= 3'd3) begin
        ref_op(op, a, b, e.hi, e.lo, lat);
        e.due = acc + lat;
        sb.push_back(e);
        m_hi = e.hi;
        m_lo = e.lo;
      end else if (op == 3'd4) begin
        m_hi = a;
      end else if (op == 3'd5) begin
        m_lo = a;
      end
    end
    @(negedge clk);
    req_valid = 1'b0;
    req_a     = $urandom;
    req_b     = $urandom;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout actual=pending%0d required=0", sb.size());
    end
  endtask

  function automatic logic [XLEN-1:0] rnd_val();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      3:       return XLEN'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done actual=1 required=0 (t=%0t)", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_hi", hi_out, e.hi);
        chk("done_lo", lo_out, e.lo);
        chk("done_cycle", cyc, e.due);
      end
    end
  end

  initial begin
    int acc;
    int bad;
    reset     = 1'b1;
    req_valid = 1'b0;
    flush     = 1'b0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    m_hi      = '0;
    m_lo      = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset_hi", hi_out, '0);
    chk("reset_lo", lo_out, '0);
    chk("reset_busy", {31'b0, busy}, '0);
    chk("reset_ready", {31'b0, req_ready}, 32'd1);

    // Directed arithmetic cases.
    issue(3'd0, 32'hFFFF_FFFD, 32'd5, 1, acc);
    issue(3'd1, 32'hFFFF_FFFF, 32'd2, 1, acc);
    issue(3'd2, -32'sd7, 32'd2, 1, acc);
    issue(3'd3, 32'd100, 32'd7, 1, acc);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1, acc);
    issue(3'd3, 32'd9, 32'd0, 1, acc);
    issue(3'd3, 32'd3, 32'd10, 1, acc);
    drain();
    chk("directed_hi", hi_out, m_hi);
    chk("directed_lo", lo_out, m_lo);

    // Flush mid-divide.
    issue(3'd4, 32'h11, 32'd0, 1, acc);
    issue(3'd5, 32'h22, 32'd0, 1, acc);
    issue(3'd2, 32'd50, 32'd3, 0, acc);
    while (cyc < acc + 9) @(negedge clk);
    chk("busy_before_flush", {31'b0, busy}, 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("flush_busy", {31'b0, busy}, '0);
    chk("flush_ready", {31'b0, req_ready}, 32'd1);
    chk("flush_hi", hi_out, 32'h11);
    chk("flush_lo", lo_out, 32'h22);

    // Flush on the completion edge.
    issue(3'd2, 32'd50, 32'd3, 0, acc);
    while (cyc < acc + XLEN + 1) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("flush_end_busy", {31'b0, busy}, '0);
    chk("flush_end_hi", hi_out, 32'h11);
    chk("flush_end_lo", lo_out, 32'h22);

    // Flush blocks an MTHI in IDLE.
    flush     = 1'b1;
    req_valid = 1'b1;
    req_op    = 3'd4;
    req_a     = 32'h99;
    #1;
    chk("flush_idle_ready", {31'b0, req_ready}, '0);
    @(negedge clk);
    flush     = 1'b0;
    req_valid = 1'b0;
    #1;
    chk("flush_idle_hi", hi_out, 32'h11);

    // MTLO right behind a MULT, accepted on the edge that ends done.
    issue(3'd0, 32'd7, 32'd6, 1, acc);
    issue(3'd5, 32'd5, 32'd0, 1, acc);
    #1;
    chk("b2b_lo", lo_out, 32'd5);
    chk("b2b_hi", hi_out, m_hi);

    // req_valid held during a divide must not be accepted early.
    issue(3'd3, 32'd1000, 32'd33, 1, acc);
    req_valid = 1'b1;
    req_op    = 3'd4;
    req_a     = 32'hAB;
    bad = 0;
    for (int i = 0; i < 60 && busy; i++) begin
      if (req_ready) bad++;
      @(negedge clk);
    end
    chk("held_valid_ready_while_busy", bad, 0);
    @(negedge clk);
    req_valid = 1'b0;
    m_hi = 32'hAB;
    drain();
    chk("held_valid_hi", hi_out, 32'hAB);
    chk("held_valid_lo", lo_out, m_lo);

    // Random traffic including reserved opcodes.
    for (int i = 0; i < 40; i++) begin
      issue(3'($urandom_range(0, 7)), rnd_val(), rnd_val(), 1, acc);
    end
    drain();
    chk("random_hi", hi_out, m_hi);
    chk("random_lo", lo_out, m_lo);

    // Reset in the middle of a divide.
    issue(3'd2, 32'd12345, 32'd7, 1, acc);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    m_hi = '0;
    m_lo = '0;
    #1;
    chk("midreset_hi", hi_out, '0);
    chk("midreset_lo", lo_out, '0);
    chk("midreset_busy", {31'b0, busy}, '0);
    issue(3'd1, 32'd3, 32'd4, 1, acc);
    drain();
    chk("after_reset_lo", lo_out, m_lo);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
